sa_operand_skewer: RTL and testbench

Downstream consumer of the dual-port BRAM read pipeline. It takes the 512-bit A and B rows that emerge from the BRAM pipeline's third delay stage and splits each row into ELEM_W-bit elements. Lane i is delayed by i cycles, so the diagonal wavefront feeds the systolic array's west edge (A) and north edge (B). A controller FSM frames one tile of DEPTH rows, zero-fills bubbles, drains the skew, and signals completion.

---
 rtl/sa_operand_skewer_pkg.sv | 12 +
 rtl/sa_operand_skewer_if.sv | 31 +++
 rtl/skew_delay_line.sv | 31 +++
 rtl/sa_operand_skewer.sv | 127 ++++++++++++
 tb/tb_sa_operand_skewer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_operand_skewer_pkg.sv
// Shared types and defaults for the systolic-array operand skewer.
package sa_skew_pkg;

   localparam int DEF_DATA_W = 512;
   localparam int DEF_ELEM_W = 16;
   localparam int DEF_DEPTH  = 4;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} skew_state_t;

   typedef logic [DEF_ELEM_W-1:0] elem_t;

endpackage

// File: rtl/sa_operand_skewer_if.sv
// Row-in / skewed-lanes-out bundle between the BRAM pipeline, the skewer and the array edges.
interface sa_operand_skewer_if
   import sa_skew_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ELEM_W = DEF_ELEM_W
);
   localparam int LANES = DATA_W / ELEM_W;

   logic                    start;
   logic                    in_valid;
   logic [DATA_W-1:0]       a_row;
   logic [DATA_W-1:0]       b_row;
   logic                    in_ready;
   logic [LANES*ELEM_W-1:0] a_out;
   logic [LANES*ELEM_W-1:0] b_out;
   logic [LANES-1:0]        lane_valid;
   logic                    busy;
   logic                    done;

   modport master (
      output start, in_valid, a_row, b_row,
      input  in_ready, a_out, b_out, lane_valid, busy, done
   );

   modport slave (
      input  start, in_valid, a_row, b_row,
      output in_ready, a_out, b_out, lane_valid, busy, done
   );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line with synchronous active-low clear; DELAY=0 is a wire.
module skew_delay_line #(
   parameter int WIDTH = 1,
   parameter int DELAY = 0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DELAY == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ clr_n;
      assign q = d;
   end else begin : g_pipe
      logic [DELAY-1:0][WIDTH-1:0] dly_pipe;

      always_ff @(posedge clk) begin
         if (!clr_n) begin
            dly_pipe <= '0;
         end else begin
            dly_pipe[0] <= d;
            for (int k = 1; k < DELAY; k++) dly_pipe[k] <= dly_pipe[k-1];
         end
      end

      assign q = dly_pipe[DELAY-1];
   end

endmodule

// File: rtl/sa_operand_skewer.sv
// Splits A/B rows into lanes and delays lane i by i cycles to form the systolic wavefront.
module sa_operand_skewer
   import sa_skew_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ELEM_W = DEF_ELEM_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   sa_operand_skewer_if.slave  bus
);

   localparam int LANES = DATA_W / ELEM_W;
   localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW    = $clog2(LANES);

   if (DATA_W % ELEM_W != 0) begin : g_bad_width
      $error("DATA_W must be a multiple of ELEM_W");
   end
   if (LANES < 2) begin : g_bad_lanes
      $error("skewer needs at least two lanes");
   end

   skew_state_t    state, state_nxt;
   logic [RW-1:0]  row_cnt, row_cnt_nxt;
   logic [DW-1:0]  drain_cnt, drain_cnt_nxt;
   logic           done_q, done_nxt;
   logic           in_ready, accept;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         row_cnt   <= '0;
         drain_cnt <= '0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         row_cnt   <= row_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
         done_q    <= done_nxt;
      end
   end

   // Leaving DRAIN one count early lands done on the cycle lane LANES-1 shows the last row.
   always_comb begin
      state_nxt     = state;
      row_cnt_nxt   = row_cnt;
      drain_cnt_nxt = drain_cnt;
      done_nxt      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt   = LOAD;
               row_cnt_nxt = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               row_cnt_nxt = row_cnt + 1'b1;
               if (row_cnt == RW'(DEPTH-1)) begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = '0;
               end
            end
         end
         DRAIN: begin
            drain_cnt_nxt = drain_cnt + 1'b1;
            if (drain_cnt == DW'(LANES-2)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == LOAD);
      accept   = in_ready & bus.in_valid;
   end

   assign bus.in_ready = in_ready;
   assign bus.busy     = (state != IDLE) | done_q;
   assign bus.done     = done_q;

   // Stage 0: anything not accepted becomes a zero bubble so accumulators see nothing.
   logic              s0_vld;
   logic [DATA_W-1:0] s0_a, s0_b;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_vld <= 1'b0;
         s0_a   <= '0;
         s0_b   <= '0;
      end else if (accept) begin
         s0_vld <= 1'b1;
         s0_a   <= bus.a_row;
         s0_b   <= bus.b_row;
      end else begin
         s0_vld <= 1'b0;
         s0_a   <= '0;
         s0_b   <= '0;
      end
   end

   wire [LANES-1:0][ELEM_W-1:0] lane_a;
   wire [LANES-1:0][ELEM_W-1:0] lane_b;
   wire [LANES-1:0]             lane_v;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      skew_delay_line #(
         .WIDTH (1 + 2*ELEM_W),
         .DELAY (i)
      ) u_dl (
         .clk   (clk),
         .clr_n (rst),
         .d     ({s0_vld, s0_a[i*ELEM_W +: ELEM_W], s0_b[i*ELEM_W +: ELEM_W]}),
         .q     ({lane_v[i], lane_a[i], lane_b[i]})
      );
   end

   assign bus.a_out      = lane_a;
   assign bus.b_out      = lane_b;
   assign bus.lane_valid = lane_v;

endmodule

// File: tb/tb_sa_operand_skewer.sv
// Randomized bench for sa_operand_skewer against a history-based lane model.
module tb_sa_operand_skewer;
   import sa_skew_pkg::*;

   localparam int DATA_W = 512;
   localparam int ELEM_W = 16;
   localparam int DEPTH  = 4;
   localparam int LANES  = DATA_W / ELEM_W;
   localparam int HIST   = 4096;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sa_operand_skewer_if #(.DATA_W(DATA_W), .ELEM_W(ELEM_W)) bus();

   sa_operand_skewer #(.DATA_W(DATA_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = -1;

   // Model: what entered stage 0 at each edge; lane i after edge n shows entry n-i.
   logic              hv [HIST];
   logic [DATA_W-1:0] ha [HIST];
   logic [DATA_W-1:0] hb [HIST];
   int  rst_edge  = 0;
   bit  m_load    = 0;
   bit  m_drain   = 0;
   int  m_rows    = 0;
   int  done_edge = -100;

   bit  bub_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   initial begin
      bit                acc, idle, exp_done;
      int                e;
      logic [DATA_W-1:0] exp_a, exp_b;
      logic [LANES-1:0]  exp_v;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst) begin
            m_load = 0; m_drain = 0; m_rows = 0; done_edge = -100;
            rst_edge = cyc;
            acc = 0;
         end else begin
            acc  = m_load && bus.in_valid;
            idle = !m_load && !m_drain;
            if (idle && bus.start) begin
               m_load = 1; m_rows = 0;
            end else if (acc) begin
               m_rows++;
               if (m_rows == DEPTH) begin
                  m_load = 0; m_drain = 1; done_edge = cyc + LANES - 1;
               end
            end else if (m_drain && cyc == done_edge) begin
               m_drain = 0;
            end
         end
         hv[cyc % HIST] = acc;
         ha[cyc % HIST] = acc ? bus.a_row : '0;
         hb[cyc % HIST] = acc ? bus.b_row : '0;
         #1;
         exp_a = '0; exp_b = '0; exp_v = '0;
         for (int i = 0; i < LANES; i++) begin
            e = cyc - i;
            if (e > rst_edge) begin
               exp_v[i] = hv[e % HIST];
               exp_a[i*ELEM_W +: ELEM_W] = ha[e % HIST][i*ELEM_W +: ELEM_W];
               exp_b[i*ELEM_W +: ELEM_W] = hb[e % HIST][i*ELEM_W +: ELEM_W];
            end
         end
         exp_done = (cyc == done_edge);
         check("in_ready",   bus.in_ready,   m_load);
         check("done",       bus.done,       exp_done);
         check("busy",       bus.busy,       m_load | m_drain | exp_done);
         check("lane_valid", bus.lane_valid, exp_v);
         check("a_out",      bus.a_out,      exp_a);
         check("b_out",      bus.b_out,      exp_b);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_in(input bit v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      bus.in_valid = v;
      bus.a_row    = a;
      bus.b_row    = b;
   endtask

   function automatic logic [DATA_W-1:0] rand_row();
      logic [DATA_W-1:0] r;
      for (int k = 0; k < DATA_W/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] pat_row(input int base);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*ELEM_W +: ELEM_W] = 16'(base + i);
      return r;
   endfunction

   task automatic do_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic run_rows(input int n, output int first, output int last);
      first = -1;
      last  = -1;
      for (int r = 0; r < n; r++) begin
         set_in(1'b1, rand_row(), rand_row());
         step();
         if (r == 0) first = cyc;
         last = cyc;
      end
      set_in(1'b0, '0, '0);
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int k = 0; k < 80; k++) begin
         if (bus.done) begin
            dc = cyc;
            break;
         end
         step();
      end
      total++;
      if (dc < 0) begin
         bad++;
         $display("FAIL wait_done at edge %0d: got no done pulse want one", cyc);
      end
   endtask

   initial begin
      int    t0, tl, dc, d1, d2, nd;
      elem_t l0;
      logic [DATA_W-1:0] row0;
      bus.start = 1'b0;
      set_in(1'b0, '0, '0);

      // Reset state.
      repeat (3) step();
      check("rst_lane_valid", bus.lane_valid, '0);
      check("rst_busy",       bus.busy,       '0);
      check("rst_in_ready",   bus.in_ready,   '0);
      rst = 1'b1;
      step();

      // Single tile with arithmetic pattern rows.
      do_start();
      t0 = -1;
      for (int r = 0; r < DEPTH; r++) begin
         set_in(1'b1, pat_row(16*r), pat_row(256 + 16*r));
         step();
         if (r == 0) t0 = cyc;
      end
      set_in(1'b0, '0, '0);
      nd = 0; dc = -1;
      for (int k = 0; k < 40; k++) begin
         if (cyc >= t0 + 5 && cyc <= t0 + 8)
            check("lane5_a", bus.a_out[5*ELEM_W +: ELEM_W], 16*(cyc - t0 - 5) + 5);
         if (cyc == t0 + 6)
            check("lane5_b", bus.b_out[5*ELEM_W +: ELEM_W], 16'h115);
         if (dc >= 0 && cyc == dc + 1) check("busy_after_done", bus.busy, '0);
         if (bus.done) begin nd++; dc = cyc; end
         step();
      end
      check("single_done_count", nd, 1);
      check("single_done_lat",   dc - (t0 + 3), 31);

      // Bubbles: valid 1,0,1,1,1 with junk data on the bubble.
      do_start();
      t0 = -1;
      for (int k = 0; k < 5; k++) begin
         set_in(bub_pat[k], rand_row(), rand_row());
         step();
         if (k == 0) t0 = cyc;
      end
      set_in(1'b0, rand_row(), rand_row());
      dc = -1;
      for (int k = 0; k < 45; k++) begin
         if (cyc >= t0 + 3 && cyc <= t0 + 7) begin
            check("bubble_lane3_v", bus.lane_valid[3], bub_pat[cyc - t0 - 3]);
            if (!bub_pat[cyc - t0 - 3])
               check("bubble_lane3_a", bus.a_out[3*ELEM_W +: ELEM_W], '0);
         end
         if (bus.done && dc < 0) dc = cyc;
         step();
      end
      check("bubble_done_lat", dc - (t0 + 4), 31);

      // Ignored inputs: in_valid in IDLE, start in LOAD and DRAIN.
      set_in(1'b1, {32{16'hDEAD}}, {32{16'hDEAD}});
      for (int k = 0; k < 3; k++) begin
         step();
         check("idle_lane_valid", bus.lane_valid, '0);
         check("idle_in_ready",   bus.in_ready,   '0);
      end
      set_in(1'b0, '0, '0);
      do_start();
      do_start();
      check("load_start_ignored", bus.in_ready, 1'b1);
      run_rows(DEPTH, t0, tl);
      bus.start = 1'b1;
      set_in(1'b1, {32{16'hDEAD}}, {32{16'hDEAD}});
      for (int k = 0; k < 3; k++) begin
         step();
         check("drain_in_ready", bus.in_ready, '0);
      end
      bus.start = 1'b0;
      set_in(1'b0, '0, '0);
      wait_done(dc);
      check("ignored_done_lat", dc - tl, 31);
      step();

      // Mid-tile reset after two accepts.
      do_start();
      run_rows(2, t0, tl);
      set_in(1'b1, rand_row(), rand_row());
      rst = 1'b0;
      step();
      rst = 1'b1;
      set_in(1'b0, '0, '0);
      check("mrst_a_out",      bus.a_out,      '0);
      check("mrst_b_out",      bus.b_out,      '0);
      check("mrst_lane_valid", bus.lane_valid, '0);
      check("mrst_busy",       bus.busy,       '0);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) nd++;
         step();
      end
      check("mrst_no_done", nd, 0);
      do_start();
      run_rows(DEPTH, t0, tl);
      wait_done(dc);
      check("mrst_fresh_done_lat", dc - tl, 31);

      // Back-to-back tiles: start issued in the done cycle.
      step();
      do_start();
      run_rows(DEPTH, t0, tl);
      wait_done(d1);
      do_start();
      row0 = rand_row();
      set_in(1'b1, row0, rand_row());
      step();
      l0 = row0[ELEM_W-1:0];
      check("b2b_lane0_v", bus.lane_valid[0], 1'b1);
      check("b2b_lane0_a", bus.a_out[ELEM_W-1:0], l0);
      check("b2b_first_edge", cyc - d1, 2);
      run_rows(DEPTH - 1, t0, tl);
      wait_done(d2);
      check("b2b_done_gap", d2 - d1, 36);

      // Random tiles with random bubbles and idle junk.
      for (int t = 0; t < 6; t++) begin
         repeat ($urandom_range(0, 3)) begin
            set_in(1'($urandom_range(0, 1)), rand_row(), rand_row());
            step();
         end
         set_in(1'b0, '0, '0);
         do_start();
         for (int k = 0; k < 60 && m_load; k++) begin
            set_in($urandom_range(0, 9) < 7, rand_row(), rand_row());
            step();
         end
         set_in(1'b0, rand_row(), rand_row());
         wait_done(dc);
      end
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
